// File: rtl/prf_free_list.sv
// Circular free list of physical-register tags, refilled from the RRAT bitmap after a mispredict.
// Optional PRF_FL_DUAL_SCAN_EN: recovery scans two bitmap bits per cycle.
module prf_free_list #(
    parameter int unsigned PRF_SIZE  = 64,
    parameter int unsigned PRF_WIDTH = 6,
    parameter int unsigned ARF_SIZE  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 RRAT_free_valid_in,
    input  logic [PRF_WIDTH-1:0] RRAT_free_PRF_num_in,
    input  logic                 RAT_alloc_req_in,
    input  logic                 mispredict_in,
    input  logic [PRF_SIZE-1:0]  RRAT_PRF_FL_in,
    output logic                 FL_alloc_valid_out,
    output logic [PRF_WIDTH-1:0] FL_alloc_PRF_num_out,
    output logic [PRF_WIDTH:0]   FL_count_out,
    output logic                 FL_recovering_out,
    output logic                 FL_error_out
);
    localparam int unsigned FreeMax = PRF_SIZE - ARF_SIZE;
    localparam logic [PRF_WIDTH:0] CountMax = (PRF_WIDTH+1)'(FreeMax);

    typedef enum logic {StIdle, StRecover} state_e;

    logic [PRF_WIDTH-1:0] r_mem [PRF_SIZE];
    logic [PRF_WIDTH-1:0] r_head, r_tail, r_idx;
    logic [PRF_WIDTH:0]   r_count;
    logic [PRF_SIZE-1:0]  r_bitmap;
    logic                 r_error;
    state_e               r_state;

    state_e               w_state_d;
    logic [PRF_WIDTH-1:0] w_head_d, w_tail_d, w_idx_d;
    logic [PRF_WIDTH:0]   w_count_d;
    logic [PRF_SIZE-1:0]  w_bitmap_d, w_onehot;
    logic                 w_error_d, w_pop, w_push_ok;
    logic                 w_we0;
    logic [PRF_WIDTH-1:0] w_wa0, w_wd0;
`ifdef PRF_FL_DUAL_SCAN_EN
    logic                 w_we1;
    logic [PRF_WIDTH-1:0] w_wa1, w_wd1;
`endif

    assign FL_alloc_valid_out   = (r_state == StIdle) && (r_count != '0);
    assign FL_alloc_PRF_num_out = r_mem[r_head];
    assign FL_count_out         = r_count;
    assign FL_recovering_out    = (r_state == StRecover);
    assign FL_error_out         = r_error;

    always_comb begin
        w_state_d  = r_state;
        w_head_d   = r_head;
        w_tail_d   = r_tail;
        w_idx_d    = r_idx;
        w_count_d  = r_count;
        w_bitmap_d = r_bitmap;
        w_error_d  = r_error;
        w_we0      = 1'b0;
        w_wa0      = r_tail;
        w_wd0      = RRAT_free_PRF_num_in;
`ifdef PRF_FL_DUAL_SCAN_EN
        w_we1      = 1'b0;
        w_wa1      = r_tail;
        w_wd1      = r_idx + PRF_WIDTH'(1);
`endif
        w_pop      = RAT_alloc_req_in && FL_alloc_valid_out;
        w_push_ok  = 1'b0;
        w_onehot   = '0;
        w_onehot[RRAT_free_PRF_num_in] = RRAT_free_valid_in;

        if (mispredict_in) begin
            // A tag freed in the flush cycle is folded into the rebuild rather than pushed.
            w_bitmap_d = RRAT_PRF_FL_in | w_onehot;
            w_head_d   = '0;
            w_tail_d   = '0;
            w_count_d  = '0;
            w_idx_d    = '0;
            w_state_d  = StRecover;
        end else if (r_state == StRecover) begin
            if (RRAT_free_valid_in) w_error_d = 1'b1;
            w_we0 = r_bitmap[r_idx];
            w_wd0 = r_idx;
`ifdef PRF_FL_DUAL_SCAN_EN
            // Upper bit lands right after the lower one so ascending order is kept.
            w_we1     = r_bitmap[w_wd1];
            w_wa1     = r_tail + PRF_WIDTH'(w_we0);
            w_tail_d  = r_tail + PRF_WIDTH'(w_we0) + PRF_WIDTH'(w_we1);
            w_count_d = r_count + (PRF_WIDTH+1)'(w_we0) + (PRF_WIDTH+1)'(w_we1);
            w_idx_d   = r_idx + PRF_WIDTH'(2);
            if (r_idx == PRF_WIDTH'(PRF_SIZE - 2)) w_state_d = StIdle;
`else
            w_tail_d  = r_tail + PRF_WIDTH'(w_we0);
            w_count_d = r_count + (PRF_WIDTH+1)'(w_we0);
            w_idx_d   = r_idx + PRF_WIDTH'(1);
            if (r_idx == PRF_WIDTH'(PRF_SIZE - 1)) w_state_d = StIdle;
`endif
        end else begin
            if (RRAT_free_valid_in) begin
                if (r_count == CountMax) begin
                    w_error_d = 1'b1;
                end else begin
                    w_push_ok = 1'b1;
                end
            end
            w_we0     = w_push_ok;
            w_tail_d  = r_tail + PRF_WIDTH'(w_push_ok);
            w_head_d  = r_head + PRF_WIDTH'(w_pop);
            w_count_d = r_count + (PRF_WIDTH+1)'(w_push_ok) - (PRF_WIDTH+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StIdle;
            r_head   <= '0;
            r_tail   <= PRF_WIDTH'(FreeMax);
            r_idx    <= '0;
            r_count  <= CountMax;
            r_bitmap <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_head   <= w_head_d;
            r_tail   <= w_tail_d;
            r_idx    <= w_idx_d;
            r_count  <= w_count_d;
            r_bitmap <= w_bitmap_d;
            r_error  <= w_error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < PRF_SIZE; i++) begin
                r_mem[i] <= (i < FreeMax) ? PRF_WIDTH'(ARF_SIZE + i) : '0;
            end
        end else begin
            if (w_we0) r_mem[w_wa0] <= w_wd0;
`ifdef PRF_FL_DUAL_SCAN_EN
            if (w_we1) r_mem[w_wa1] <= w_wd1;
`endif
        end
    end

endmodule

// File: tb/tb_prf_free_list.sv
// Randomised bench for prf_free_list against a queue-based model, plus directed literal checks.
module tb_prf_free_list;
    localparam int PRF_SIZE = 64;
    localparam int ARF_SIZE = 32;
    localparam int FREE_MAX = PRF_SIZE - ARF_SIZE;
`ifdef PRF_FL_DUAL_SCAN_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        free_valid;
    logic [5:0]  free_num;
    logic        alloc_req;
    logic        mispredict;
    logic [63:0] bitmap;
    logic        alloc_valid;
    logic [5:0]  alloc_num;
    logic [6:0]  count;
    logic        recovering;
    logic        error;

    always #5 clock = ~clock;

    prf_free_list dut (
        .clock                (clock),
        .reset                (reset),
        .RRAT_free_valid_in   (free_valid),
        .RRAT_free_PRF_num_in (free_num),
        .RAT_alloc_req_in     (alloc_req),
        .mispredict_in        (mispredict),
        .RRAT_PRF_FL_in       (bitmap),
        .FL_alloc_valid_out   (alloc_valid),
        .FL_alloc_PRF_num_out (alloc_num),
        .FL_count_out         (count),
        .FL_recovering_out    (recovering),
        .FL_error_out         (error)
    );

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;
    int          fl[$];
    bit          m_err;
    bit          m_rec;
    int          rec_pos;
    logic [63:0] m_bm;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance for one rising edge, from the inputs presented before it.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (reset) begin
            fl.delete();
            for (int i = 0; i < FREE_MAX; i++) fl.push_back(ARF_SIZE + i);
            m_err = 0;
            m_rec = 0;
        end else if (mispredict) begin
            m_bm = bitmap;
            if (free_valid) m_bm[free_num] = 1'b1;
            fl.delete();
            m_rec   = 1;
            rec_pos = 0;
        end else if (m_rec) begin
            if (free_valid) m_err = 1;
            for (int s = 0; s < STEP; s++) begin
                if (m_bm[rec_pos]) fl.push_back(rec_pos);
                rec_pos++;
            end
            if (rec_pos == PRF_SIZE) m_rec = 0;
        end else begin
            do_pop  = alloc_req && (fl.size() != 0);
            do_push = 0;
            if (free_valid) begin
                if (fl.size() == FREE_MAX) m_err = 1;
                else do_push = 1;
            end
            if (do_pop) void'(fl.pop_front());
            if (do_push) fl.push_back(int'(free_num));
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("alloc_valid", alloc_valid, (!m_rec && fl.size() != 0));
            if (!m_rec && fl.size() != 0) chk("alloc_tag", alloc_num, fl[0]);
            chk("count", count, fl.size());
            chk("recovering", recovering, m_rec);
            chk("error", error, m_err);
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic drive(input logic fv, input logic [5:0] ft, input logic ar,
                         input logic mp, input logic [63:0] bm);
        reset      = 1'b0;
        free_valid = fv;
        free_num   = ft;
        alloc_req  = ar;
        mispredict = mp;
        bitmap     = bm;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        logic [63:0] bm;
        drive(0, 0, 0, 0, '0);
        do_reset();
        chk_en = 1;

        chk("rst_count", count, 32);
        chk("rst_valid", alloc_valid, 1);
        chk("rst_tag", alloc_num, 32);
        chk("rst_recovering", recovering, 0);
        chk("rst_error", error, 0);

        for (int i = 0; i < 32; i++) begin
            chk("drain_tag", alloc_num, 32 + i);
            drive(0, 0, 1, 0, '0);
            tick();
        end
        chk("empty_count", count, 0);
        chk("empty_valid", alloc_valid, 0);
        drive(0, 0, 1, 0, '0);
        tick();
        chk("underflow_count", count, 0);
        chk("underflow_error", error, 0);

        // No bypass from an empty list.
        drive(1, 5, 1, 0, '0);
        tick();
        chk("nobypass_valid", alloc_valid, 1);
        chk("nobypass_tag", alloc_num, 5);
        chk("nobypass_count", count, 1);

        for (int i = 0; i < 9; i++) begin
            drive(1, 6'(20 + i), 0, 0, '0);
            tick();
        end
        chk("fill10_count", count, 10);
        drive(1, 7, 1, 0, '0);
        tick();
        chk("pushpop_count", count, 10);
        for (int i = 0; i < 9; i++) begin
            chk("older_tag", alloc_num, 20 + i);
            drive(0, 0, 1, 0, '0);
            tick();
        end
        chk("tag7_emerges", alloc_num, 7);

        bm = '0;
        bm[40] = 1'b1;
        bm[41] = 1'b1;
        bm[63] = 1'b1;
        drive(0, 0, 1, 1, bm);
        tick();
        n = 0;
        drive(0, 0, 0, 0, '0);
        while (recovering === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("recover_len", n, 64 / STEP);
        chk("recover_count", count, 3);
        chk("recover_tag0", alloc_num, 40);
        drive(0, 0, 1, 0, '0);
        tick();
        chk("recover_tag1", alloc_num, 41);
        tick();
        chk("recover_tag2", alloc_num, 63);
        tick();
        chk("recover_empty", count, 0);

        do_reset();
        drive(1, 12, 0, 0, '0);
        tick();
        chk("overflow_count", count, 32);
        chk("overflow_error", error, 1);
        drive(0, 0, 1, 0, '0);
        repeat (3) tick();
        chk("error_sticky", error, 1);
        do_reset();
        chk("error_cleared", error, 0);

        for (int it = 0; it < 5000; it++) begin
            r = $urandom_range(0, 999);
            bm = '0;
            n = $urandom_range(0, 32);
            for (int k = 0; k < n; k++) bm[$urandom_range(0, 63)] = 1'b1;
            drive(m_rec ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 45),
                  6'($urandom_range(0, 63)), ($urandom_range(0, 99) < 50),
                  (r >= 3 && r < 23), bm);
            if (r < 3) reset = 1'b1;
            tick();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
